// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out serializer.
package piso_pkg;

    // Bit order latched with each accepted word.
    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    // Beat counter width: one spare bit above what BEATS needs.
    function automatic int unsigned beat_cnt_width(input int unsigned beats);
        return $clog2(beats) + 1;
    endfunction

endpackage

// File: rtl/piso_hold_buf.sv
// Single-entry holding register that parks the next word while the shifter is busy.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_word,
    input  bit_order_e       push_order,
    input  logic             pop,
    output logic [WIDTH-1:0] word,
    output bit_order_e       order,
    output logic             full
);

    // Capture on push; a pop empties the entry (push and pop never coincide).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word  <= '0;
            order <= MSB_FIRST;
            full  <= 1'b0;
        end else begin
            if (push) begin
                word  <= push_word;
                order <= push_order;
            end
            if (push) begin
                full <= 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer: one active shifter plus a one-word holding
// register, LANES bits per beat, bit order chosen per word.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LANES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             lsb_first,
    input  logic             ser_en,
    output logic [LANES-1:0] ser_out,
    output logic             ser_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CW    = beat_cnt_width(BEATS);

    if (WIDTH < 2 || LANES == 0 || (WIDTH % LANES) != 0) begin : g_param_check
        $error("piso_serializer: WIDTH must be >= 2 and an integer multiple of LANES");
    end

    logic [WIDTH-1:0] shreg;
    bit_order_e       shift_order;
    logic             shift_full;
    logic [CW-1:0]    beat_cnt;

    logic [WIDTH-1:0] hold_word;
    bit_order_e       hold_order;
    logic             hold_full;

    logic             accept_c;
    logic             beat_c;
    logic             last_c;
    logic             shift_free_c;
    logic             load_hold_c;
    logic             load_in_c;
    logic             push_c;
    logic             shift_full_next_c;
    logic             hold_full_next_c;
    logic [LANES-1:0] lane_c;

    // Handshake and buffer steering: the shifter takes the held word first, else the
    // incoming word when it is empty or draining its last beat; otherwise park it.
    always_comb begin
        accept_c          = in_valid & in_ready;
        beat_c            = ser_en & shift_full;
        last_c            = beat_c & (beat_cnt == CW'(BEATS - 1));
        shift_free_c      = ~shift_full | last_c;
        load_hold_c       = shift_free_c & hold_full;
        load_in_c         = shift_free_c & ~hold_full & accept_c;
        push_c            = accept_c & ~load_in_c;
        shift_full_next_c = load_hold_c | load_in_c | (shift_full & ~last_c);
        hold_full_next_c  = push_c | (hold_full & ~load_hold_c);
    end

    // Current beat: the low lanes for LSB-first, the high lanes for MSB-first.
    always_comb begin
        lane_c = (shift_order == LSB_FIRST) ? shreg[LANES-1:0] : shreg[WIDTH-1 -: LANES];
    end

    piso_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_word (in_data),
        .push_order(bit_order_e'(lsb_first)),
        .pop       (load_hold_c),
        .word      (hold_word),
        .order     (hold_order),
        .full      (hold_full)
    );

    // Shifter and beat counter; a reload on the last beat overrides the shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            shift_order <= MSB_FIRST;
            shift_full  <= 1'b0;
            beat_cnt    <= '0;
        end else begin
            if (beat_c) begin
                shreg    <= (shift_order == LSB_FIRST) ? (shreg >> LANES) : (shreg << LANES);
                beat_cnt <= beat_cnt + CW'(1);
            end
            if (load_hold_c) begin
                shreg       <= hold_word;
                shift_order <= hold_order;
                beat_cnt    <= '0;
            end else if (load_in_c) begin
                shreg       <= in_data;
                shift_order <= bit_order_e'(lsb_first);
                beat_cnt    <= '0;
            end else if (last_c) begin
                beat_cnt <= '0;
            end
            shift_full <= shift_full_next_c;
        end
    end

    // Registered outputs: serial beat, frame strobe, and occupancy flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ser_out    <= '0;
            ser_valid  <= 1'b0;
            frame_done <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (ser_en) begin
                ser_valid <= shift_full;
                if (shift_full) begin
                    ser_out <= lane_c;
                end
            end
            frame_done <= last_c;
            in_ready   <= ~hold_full_next_c;
            busy       <= shift_full_next_c | hold_full_next_c;
        end
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, at least 2.
REQ-002 SHALL have parameter LANES, default 1: serial lanes driven per beat; WIDTH mod LANES SHALL be 0 (elaboration error otherwise).
REQ-003 SHALL have port clk, input, 1: clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_data is offered this cycle.
REQ-006 SHALL have port in_ready, output, 1: block can accept a word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH: parallel word.
REQ-008 SHALL have port lsb_first, input, 1: bit order, sampled with each accepted word.
REQ-009 SHALL have port ser_en, input, 1: beat strobe; one beat advances per cycle with ser_en=1.
REQ-010 SHALL have port ser_out, output, LANES: serial data of the current beat.
REQ-011 SHALL have port ser_valid, output, 1: ser_out carries frame data.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse issued with the last beat of a word.
REQ-013 SHALL have port busy, output, 1: shifter or holding register occupied.

Function
REQ-014 SHALL compute BEATS = WIDTH/LANES; beat counter width SHALL be clog2(BEATS)+1.
REQ-015 SHALL hold two words: an active shifter and one holding register; in_ready SHALL equal NOT(holding register full), with no combinational path from in_valid.
REQ-016 SHALL accept a word only when in_valid=1 and in_ready=1; the word goes to the shifter if the shifter is empty or finishes its last beat this cycle, else to the holding register.
REQ-017 SHALL, on a ser_en cycle with the shifter loaded, register the next beat into ser_out, set ser_valid=1, and increment the beat count.
REQ-018 MSB-first beat k (0-based) SHALL be in_data[WIDTH-1-k*LANES -: LANES]; LSB-first beat k SHALL be in_data[k*LANES +: LANES], with ser_out[0] carrying bit k*LANES.
REQ-019 SHALL, on a ser_en cycle with the shifter empty, set ser_valid=0 and hold ser_out; on cycles with ser_en=0, ser_out and ser_valid SHALL hold.
REQ-020 First beat latency: a word accepted into an empty shifter at cycle N SHALL appear on ser_out at the first ser_en cycle after N (earliest N+1).
REQ-021 SHALL pulse frame_done for exactly one cycle on the clock edge that registers beat BEATS-1.
REQ-022 On the last beat with the holding register full, the shifter SHALL reload from the holding register on the same edge so the next word's beat 0 follows on the next ser_en, with no idle beat.
REQ-023 Accept and last beat in the same cycle with the holding register empty SHALL load the shifter directly; the holding register SHALL remain empty.
REQ-024 busy SHALL be 1 whenever the shifter or the holding register is occupied.

Reset
REQ-025 While reset is asserted, SHALL set ser_out=0, ser_valid=0, frame_done=0, busy=0, in_ready=0, and clear both buffers and the beat count.
REQ-026 SHALL set in_ready=1 on the first clock after reset deasserts.
REQ-027 Reset mid-frame SHALL discard the partial word and any held word; no frame_done SHALL be issued for either.

Structure
REQ-028 Package piso_pkg SHALL hold the bit-order enum (MSB_FIRST=0, LSB_FIRST=1) and a function computing the beat-counter width.
REQ-029 The holding register with its full flag and stored lsb_first bit SHALL be sub-module piso_hold_buf; shifter, lane selection and counter stay in piso_serializer.

Verification
REQ-030 Bench SHALL cover: WIDTH=8, LANES=1, 0xB4 MSB-first, ser_en=1 -> ser_out 1,0,1,1,0,1,0,0; frame_done on the 8th beat.
REQ-031 Bench SHALL cover: same setup with lsb_first=1, 0xB4 -> ser_out 0,0,1,0,1,1,0,1.
REQ-032 Bench SHALL cover: LANES=2, 0xB4 MSB-first -> ser_out 2'b10, 2'b11, 2'b01, 2'b00; frame_done with the 4th beat.
REQ-033 Bench SHALL cover: 0x0F then 0xF0 offered back-to-back, ser_en=1 -> 16 contiguous valid beats; in_ready=0 while the holding register is full; two frame_done pulses, 8 cycles apart.
REQ-034 Bench SHALL cover: ser_en asserted every 4th cycle -> beats advance only on strobes; ser_out and ser_valid stable between strobes.
REQ-035 Bench SHALL cover: reset asserted after 3 beats of 0xB4 with 0x55 held -> all outputs 0 immediately; no frame_done; a new word 0x81 afterwards serializes correctly.
